// File: rtl/hazard_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_pkg
//  Description : Shared types and helpers for the pipeline hazard controller:
//                controller state encoding, forwarding-select codes and the
//                register-match helper (r0 never creates a dependency).
//  Revision    : 1.0 - initial release
// ============================================================================
package hazard_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    STALL    = 2'd1,
    MEM_WAIT = 2'd2
  } state_t;

  localparam logic [1:0] FWD_REG    = 2'b00;
  localparam logic [1:0] FWD_EX_MEM = 2'b01;
  localparam logic [1:0] FWD_WB     = 2'b10;

  // A producer register matches a consumer only when it is not r0.
  function automatic logic reg_match(input logic [4:0] dst, input logic [4:0] src);
    return (dst != 5'd0) && (dst == src);
  endfunction

endpackage
`default_nettype wire

// File: rtl/forwarding_unit.sv
`default_nettype none
// ============================================================================
//  Module      : forwarding_unit
//  Description : Purely combinational ALU operand forwarding selects.
//                The MEM-stage result is newer than the WB-stage result, so it
//                wins when both target the same source register.
//  Ports       : ID_EX_rs/_rt        in  5  EX-stage source registers
//                EX_MEM_rd/_reg_write in     MEM-stage destination / write enable
//                MEM_WB_rd/_reg_write in     WB-stage destination / write enable
//                forward_A/_B        out 2  operand selects (00 reg, 01 MEM, 10 WB)
//  Revision    : 1.0 - initial release
// ============================================================================
module forwarding_unit
  import hazard_pkg::*;
(
  input  logic [4:0] ID_EX_rs,
  input  logic [4:0] ID_EX_rt,
  input  logic [4:0] EX_MEM_rd,
  input  logic       EX_MEM_reg_write,
  input  logic [4:0] MEM_WB_rd,
  input  logic       MEM_WB_reg_write,
  output logic [1:0] forward_A,
  output logic [1:0] forward_B
);

  always_comb begin
    forward_A = FWD_REG;
    if (EX_MEM_reg_write && reg_match(EX_MEM_rd, ID_EX_rs)) begin
      forward_A = FWD_EX_MEM;
    end else if (MEM_WB_reg_write && reg_match(MEM_WB_rd, ID_EX_rs)) begin
      forward_A = FWD_WB;
    end
  end

  always_comb begin
    forward_B = FWD_REG;
    if (EX_MEM_reg_write && reg_match(EX_MEM_rd, ID_EX_rt)) begin
      forward_B = FWD_EX_MEM;
    end else if (MEM_WB_reg_write && reg_match(MEM_WB_rd, ID_EX_rt)) begin
      forward_B = FWD_WB;
    end
  end

endmodule
`default_nettype wire

// File: rtl/pipeline_hazard_controller.sv
`default_nettype none
// ============================================================================
//  Module      : pipeline_hazard_controller
//  Description : Hazard sequencer for a 5-stage pipeline. Generates forwarding
//                selects, load-use / branch-operand bubbles, branch and jump
//                redirects, whole-pipe freeze during multi-cycle data-memory
//                accesses, a sticky memory-timeout flag and saturating
//                performance counters.
//  Ports       : clk, rst (async, active-low)
//                IF_ID_*/ID_EX_*/EX_MEM_*/MEM_WB_*  pipeline register fields
//                branch, jump, equal                decoder / comparator in ID
//                dmem_req, dmem_ready               data-memory handshake
//                pc_write, IF_ID_write, IF_ID_flush, mux_hz_sel, pipe_hold,
//                pc_src, pc_jump, forward_A/_B      datapath controls
//                mem_err                            sticky timeout flag
//                cyc_cnt, stall_cnt, flush_cnt      saturating counters
//  Revision    : 1.0 - initial release
// ============================================================================
module pipeline_hazard_controller
  import hazard_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       IF_ID_rs,
  input  logic [4:0]       IF_ID_rt,
  input  logic [4:0]       ID_EX_rs,
  input  logic [4:0]       ID_EX_rt,
  input  logic [4:0]       ID_EX_dst,
  input  logic             ID_EX_mem_read,
  input  logic             ID_EX_reg_write,
  input  logic [4:0]       EX_MEM_rd,
  input  logic             EX_MEM_reg_write,
  input  logic             EX_MEM_mem_read,
  input  logic [4:0]       MEM_WB_rd,
  input  logic             MEM_WB_reg_write,
  input  logic             branch,
  input  logic             jump,
  input  logic             equal,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  output logic             pc_write,
  output logic             IF_ID_write,
  output logic             IF_ID_flush,
  output logic             mux_hz_sel,
  output logic             pipe_hold,
  output logic             pc_src,
  output logic             pc_jump,
  output logic [1:0]       forward_A,
  output logic [1:0]       forward_B,
  output logic             mem_err,
  output logic [CNT_W-1:0] cyc_cnt,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int              TMO_W    = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(MEM_TIMEOUT - 1);

  state_t           state, state_nxt;
  logic [1:0]       bubbles, bubbles_nxt;
  logic [TMO_W-1:0] tmo, tmo_nxt;
  logic             set_err;
  logic             mem_busy;
  logic [1:0]       need;
  logic             ex_hit, mem_hit;

  forwarding_unit u_fwd (
    .ID_EX_rs         (ID_EX_rs),
    .ID_EX_rt         (ID_EX_rt),
    .EX_MEM_rd        (EX_MEM_rd),
    .EX_MEM_reg_write (EX_MEM_reg_write),
    .MEM_WB_rd        (MEM_WB_rd),
    .MEM_WB_reg_write (MEM_WB_reg_write),
    .forward_A        (forward_A),
    .forward_B        (forward_B)
  );

  assign mem_busy = dmem_req & ~dmem_ready;
  assign ex_hit   = reg_match(ID_EX_dst, IF_ID_rs) | reg_match(ID_EX_dst, IF_ID_rt);
  assign mem_hit  = reg_match(EX_MEM_rd, IF_ID_rs) | reg_match(EX_MEM_rd, IF_ID_rt);

  // Bubbles required by the instruction in ID. A branch compares in ID, so a
  // load feeding it from EX needs the load to reach WB (two bubbles).
  always_comb begin
    need = 2'd0;
    if (branch && ID_EX_mem_read && ex_hit) begin
      need = 2'd2;
    end else if ((ID_EX_mem_read && ex_hit) ||
                 (branch && ID_EX_reg_write && !ID_EX_mem_read && ex_hit) ||
                 (branch && EX_MEM_mem_read && mem_hit)) begin
      need = 2'd1;
    end
  end

  always_comb begin
    state_nxt   = state;
    bubbles_nxt = bubbles;
    tmo_nxt     = tmo;
    set_err     = 1'b0;
    pc_write    = 1'b1;
    IF_ID_write = 1'b1;
    IF_ID_flush = 1'b0;
    mux_hz_sel  = 1'b0;
    pipe_hold   = 1'b0;
    pc_src      = 1'b0;
    pc_jump     = 1'b0;
    case (state)
      RUN: begin
        if (mem_busy) begin
          pc_write    = 1'b0;
          IF_ID_write = 1'b0;
          pipe_hold   = 1'b1;
          tmo_nxt     = '0;
          state_nxt   = MEM_WAIT;
        end else if (need != 2'd0) begin
          pc_write    = 1'b0;
          IF_ID_write = 1'b0;
          mux_hz_sel  = 1'b1;
          bubbles_nxt = need - 2'd1;
          if (need > 2'd1) state_nxt = STALL;
        end else if (jump) begin
          pc_jump     = 1'b1;
          IF_ID_flush = 1'b1;
        end else if (branch && equal) begin
          pc_src      = 1'b1;
          IF_ID_flush = 1'b1;
        end
      end
      STALL: begin
        // A memory access in MEM must still freeze the pipe; the owed bubbles
        // are kept and resumed once memory releases.
        if (mem_busy) begin
          pc_write    = 1'b0;
          IF_ID_write = 1'b0;
          pipe_hold   = 1'b1;
          tmo_nxt     = '0;
          state_nxt   = MEM_WAIT;
        end else begin
          pc_write    = 1'b0;
          IF_ID_write = 1'b0;
          mux_hz_sel  = 1'b1;
          if (bubbles <= 2'd1) begin
            bubbles_nxt = 2'd0;
            state_nxt   = RUN;
          end else begin
            bubbles_nxt = bubbles - 2'd1;
          end
        end
      end
      MEM_WAIT: begin
        if (dmem_ready) begin
          // Releasing with bubbles still owed keeps the PC frozen so the
          // stalled instruction in ID cannot slip past its hazard.
          if (bubbles != 2'd0) begin
            pc_write    = 1'b0;
            IF_ID_write = 1'b0;
            mux_hz_sel  = 1'b1;
            state_nxt   = STALL;
          end else begin
            state_nxt   = RUN;
          end
        end else begin
          pc_write    = 1'b0;
          IF_ID_write = 1'b0;
          pipe_hold   = 1'b1;
          if (tmo == TMO_LAST) begin
            set_err = 1'b1;
          end else begin
            tmo_nxt = tmo + TMO_W'(1);
          end
        end
      end
      default: begin
        state_nxt   = RUN;
        bubbles_nxt = 2'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= RUN;
      bubbles   <= 2'd0;
      tmo       <= '0;
      mem_err   <= 1'b0;
      cyc_cnt   <= '0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      state   <= state_nxt;
      bubbles <= bubbles_nxt;
      tmo     <= tmo_nxt;
      if (set_err) mem_err <= 1'b1;
      if (cyc_cnt != '1) cyc_cnt <= cyc_cnt + CNT_W'(1);
      if ((mux_hz_sel || pipe_hold) && (stall_cnt != '1)) stall_cnt <= stall_cnt + CNT_W'(1);
      if (IF_ID_flush && (flush_cnt != '1)) flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pipeline_hazard_controller.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pipeline_hazard_controller
//  Description : Self-checking bench: directed scenarios followed by random
//                pipeline traffic, all compared against a behavioural model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pipeline_hazard_controller;

  localparam int MEM_TIMEOUT = 4;
  localparam int CNT_W       = 8;
  localparam int CMAX        = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [4:0] IF_ID_rs, IF_ID_rt, ID_EX_rs, ID_EX_rt, ID_EX_dst, EX_MEM_rd, MEM_WB_rd;
  logic ID_EX_mem_read, ID_EX_reg_write, EX_MEM_reg_write, EX_MEM_mem_read, MEM_WB_reg_write;
  logic branch, jump, equal, dmem_req, dmem_ready;
  logic pc_write, IF_ID_write, IF_ID_flush, mux_hz_sel, pipe_hold, pc_src, pc_jump, mem_err;
  logic [1:0] forward_A, forward_B;
  logic [CNT_W-1:0] cyc_cnt, stall_cnt, flush_cnt;

  int checks = 0;
  int failures = 0;

  // Model state: mode 0 = running, 1 = owing bubbles, 2 = waiting on memory.
  int m_mode, m_owed, m_wait, m_err, m_cyc, m_stall, m_flush;
  int n_mode, n_owed, n_wait, n_err, n_cyc, n_stall, n_flush;
  int e_pcw, e_flush, e_bub, e_hold, e_src, e_jmp, e_fa, e_fb;

  pipeline_hazard_controller #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .IF_ID_rs(IF_ID_rs), .IF_ID_rt(IF_ID_rt),
    .ID_EX_rs(ID_EX_rs), .ID_EX_rt(ID_EX_rt), .ID_EX_dst(ID_EX_dst),
    .ID_EX_mem_read(ID_EX_mem_read), .ID_EX_reg_write(ID_EX_reg_write),
    .EX_MEM_rd(EX_MEM_rd), .EX_MEM_reg_write(EX_MEM_reg_write), .EX_MEM_mem_read(EX_MEM_mem_read),
    .MEM_WB_rd(MEM_WB_rd), .MEM_WB_reg_write(MEM_WB_reg_write),
    .branch(branch), .jump(jump), .equal(equal),
    .dmem_req(dmem_req), .dmem_ready(dmem_ready),
    .pc_write(pc_write), .IF_ID_write(IF_ID_write), .IF_ID_flush(IF_ID_flush),
    .mux_hz_sel(mux_hz_sel), .pipe_hold(pipe_hold), .pc_src(pc_src), .pc_jump(pc_jump),
    .forward_A(forward_A), .forward_B(forward_B), .mem_err(mem_err),
    .cyc_cnt(cyc_cnt), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int sat(input int x);
    return (x > CMAX) ? CMAX : x;
  endfunction

  function automatic bit hit(input int d, input int a, input int b);
    return (d != 0) && ((d == a) || (d == b));
  endfunction

  function automatic int fwd(input int src);
    if (EX_MEM_reg_write && EX_MEM_rd != 0 && EX_MEM_rd == src) return 1;
    if (MEM_WB_reg_write && MEM_WB_rd != 0 && MEM_WB_rd == src) return 2;
    return 0;
  endfunction

  function automatic int need_now();
    int n = 0;
    bit exh = hit(ID_EX_dst, IF_ID_rs, IF_ID_rt);
    bit mmh = hit(EX_MEM_rd, IF_ID_rs, IF_ID_rt);
    if (ID_EX_mem_read && exh) n = 1;
    if (branch && ID_EX_reg_write && !ID_EX_mem_read && exh) n = 1;
    if (branch && EX_MEM_mem_read && mmh) n = 1;
    if (branch && ID_EX_mem_read && exh) n = 2;
    return n;
  endfunction

  // Expected outputs for the current inputs, plus the state after the edge.
  task automatic model_eval();
    int nd;
    e_pcw = 1; e_flush = 0; e_bub = 0; e_hold = 0; e_src = 0; e_jmp = 0;
    e_fa = fwd(ID_EX_rs);
    e_fb = fwd(ID_EX_rt);
    n_mode = m_mode; n_owed = m_owed; n_wait = m_wait; n_err = m_err;
    if (m_mode == 2) begin
      if (dmem_ready) begin
        if (m_owed > 0) begin e_pcw = 0; e_bub = 1; n_mode = 1; end
        else n_mode = 0;
      end else begin
        e_pcw = 0; e_hold = 1;
        if (m_wait == MEM_TIMEOUT - 1) n_err = 1; else n_wait = m_wait + 1;
      end
    end else if (dmem_req && !dmem_ready) begin
      e_pcw = 0; e_hold = 1; n_mode = 2; n_wait = 0;
    end else if (m_mode == 1) begin
      e_pcw = 0; e_bub = 1; n_owed = m_owed - 1;
      if (n_owed <= 0) begin n_owed = 0; n_mode = 0; end
    end else begin
      nd = need_now();
      if (nd > 0) begin
        e_pcw = 0; e_bub = 1; n_owed = nd - 1; n_mode = (nd > 1) ? 1 : 0;
      end else if (jump) begin
        e_jmp = 1; e_flush = 1;
      end else if (branch && equal) begin
        e_src = 1; e_flush = 1;
      end
    end
    n_cyc   = sat(m_cyc + 1);
    n_stall = sat(m_stall + ((e_bub || e_hold) ? 1 : 0));
    n_flush = sat(m_flush + e_flush);
  endtask

  task automatic compare_all();
    check_eq("pc_write", pc_write, e_pcw);
    check_eq("IF_ID_write", IF_ID_write, e_pcw);
    check_eq("IF_ID_flush", IF_ID_flush, e_flush);
    check_eq("mux_hz_sel", mux_hz_sel, e_bub);
    check_eq("pipe_hold", pipe_hold, e_hold);
    check_eq("pc_src", pc_src, e_src);
    check_eq("pc_jump", pc_jump, e_jmp);
    check_eq("forward_A", forward_A, e_fa);
    check_eq("forward_B", forward_B, e_fb);
    check_eq("mem_err", mem_err, m_err);
    check_eq("cyc_cnt", cyc_cnt, m_cyc);
    check_eq("stall_cnt", stall_cnt, m_stall);
    check_eq("flush_cnt", flush_cnt, m_flush);
  endtask

  // Called at posedge+1 with inputs already applied; returns at next posedge+1.
  task automatic step();
    model_eval();
    @(negedge clk);
    compare_all();
    @(posedge clk);
    #1;
    m_mode = n_mode; m_owed = n_owed; m_wait = n_wait; m_err = n_err;
    m_cyc = n_cyc; m_stall = n_stall; m_flush = n_flush;
  endtask

  task automatic clr_in();
    IF_ID_rs = 0; IF_ID_rt = 0; ID_EX_rs = 0; ID_EX_rt = 0; ID_EX_dst = 0;
    ID_EX_mem_read = 0; ID_EX_reg_write = 0; EX_MEM_rd = 0; EX_MEM_reg_write = 0;
    EX_MEM_mem_read = 0; MEM_WB_rd = 0; MEM_WB_reg_write = 0;
    branch = 0; jump = 0; equal = 0; dmem_req = 0; dmem_ready = 0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    clr_in();
    m_mode = 0; m_owed = 0; m_wait = 0; m_err = 0; m_cyc = 0; m_stall = 0; m_flush = 0;
    #2;
    model_eval();
    compare_all();
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  initial begin
    clr_in();
    #1;
    do_reset();

    // lw $2 ; add $3,$2,$4 : one bubble, then WB forwarding on rs
    IF_ID_rs = 2; IF_ID_rt = 4; ID_EX_dst = 2; ID_EX_mem_read = 1; ID_EX_reg_write = 1;
    step();
    check_eq("lu_stall_cnt", stall_cnt, 1);
    clr_in(); IF_ID_rs = 2; IF_ID_rt = 4; EX_MEM_rd = 2; EX_MEM_reg_write = 1; EX_MEM_mem_read = 1;
    step();
    clr_in(); ID_EX_rs = 2; ID_EX_rt = 4; MEM_WB_rd = 2; MEM_WB_reg_write = 1;
    step();
    check_eq("lu_stall_once", stall_cnt, 1);

    // add $5 ; sub $6,$5,$5 : no stall, both operands from MEM stage
    clr_in(); ID_EX_rs = 5; ID_EX_rt = 5; EX_MEM_rd = 5; EX_MEM_reg_write = 1; MEM_WB_rd = 5; MEM_WB_reg_write = 1;
    step();
    // r0 never forwards nor stalls
    clr_in(); ID_EX_rs = 0; EX_MEM_reg_write = 1; MEM_WB_reg_write = 1;
    IF_ID_rs = 0; ID_EX_dst = 0; ID_EX_mem_read = 1; branch = 1;
    step();

    // lw $7 ; beq $7,$1 taken : two bubbles, then one redirect
    do_reset();
    IF_ID_rs = 7; IF_ID_rt = 1; branch = 1; equal = 1; ID_EX_dst = 7; ID_EX_mem_read = 1; ID_EX_reg_write = 1;
    step();
    clr_in(); IF_ID_rs = 7; IF_ID_rt = 1; branch = 1; equal = 1; EX_MEM_rd = 7; EX_MEM_mem_read = 1; EX_MEM_reg_write = 1;
    step();
    clr_in(); IF_ID_rs = 7; IF_ID_rt = 1; branch = 1; equal = 1; MEM_WB_rd = 7; MEM_WB_reg_write = 1;
    step();
    check_eq("br_ld_flush_cnt", flush_cnt, 1);
    check_eq("br_ld_stall_cnt", stall_cnt, 2);

    // three cycles of memory wait
    do_reset();
    dmem_req = 1;
    for (int i = 0; i < 3; i++) step();
    dmem_ready = 1;
    step();
    check_eq("mw_stall_cnt", stall_cnt, 3);

    // memory never ready: flag sets on the last allowed wait cycle
    do_reset();
    dmem_req = 1;
    for (int i = 0; i < MEM_TIMEOUT; i++) step();
    check_eq("tmo_not_yet", mem_err, 0);
    step();
    check_eq("tmo_set", mem_err, 1);
    dmem_ready = 1;
    step();
    clr_in();
    step();
    check_eq("tmo_sticky", mem_err, 1);

    // reset while owing a bubble
    do_reset();
    IF_ID_rs = 7; branch = 1; ID_EX_dst = 7; ID_EX_mem_read = 1;
    step();
    do_reset();
    step();

    // random traffic, long enough to saturate cyc_cnt
    for (int i = 0; i < 400; i++) begin
      IF_ID_rs = 5'($urandom_range(0, 3)); IF_ID_rt = 5'($urandom_range(0, 3));
      ID_EX_rs = 5'($urandom_range(0, 3)); ID_EX_rt = 5'($urandom_range(0, 3));
      ID_EX_dst = 5'($urandom_range(0, 3)); EX_MEM_rd = 5'($urandom_range(0, 3));
      MEM_WB_rd = 5'($urandom_range(0, 3));
      ID_EX_mem_read = 1'($urandom); ID_EX_reg_write = 1'($urandom);
      EX_MEM_reg_write = 1'($urandom); EX_MEM_mem_read = 1'($urandom);
      MEM_WB_reg_write = 1'($urandom);
      branch = 1'($urandom); jump = ($urandom_range(0, 5) == 0); equal = 1'($urandom);
      dmem_req = ($urandom_range(0, 4) == 0); dmem_ready = ($urandom_range(0, 2) == 0);
      step();
    end
    check_eq("cyc_saturated", cyc_cnt, CMAX);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
